// File: rtl/prio_enc_rr.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_rr
//  Description : Registered N-input priority encoder / arbiter. Request pulses
//                are captured stickily, the grant order is fixed (highest
//                index wins) or round-robin, and the granted index is
//                presented through a valid/ready output register together
//                with a count of requests still waiting.
//  Revision    : 1.0  initial release
// ============================================================================
module prio_enc_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [W:0]   pend_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] last_q, last_d;
  logic [W:0]   cnt_q, cnt_d;

  logic [N-1:0] w_cand;
  logic         w_load;
  logic [W-1:0] w_win_fix;
  logic [W-1:0] w_win_rr;
  logic [W-1:0] w_win;

  // Everything seen so far plus whatever is asserted this cycle competes.
  assign w_cand = pending_q | req;
  assign w_load = (state_q == S_IDLE) || out_ready;

  // Fixed order: the highest set index of the candidates wins.
  always_comb begin
    w_win_fix = '0;
    for (int i = 0; i < N; i++) begin
      if (w_cand[i[W-1:0]]) w_win_fix = W'(i);
    end
  end

  // Round-robin: scan from lowest to highest priority so the last hit kept
  // is the first set bit after last-1, last-2, ... wrapping; last is lowest.
  always_comb begin
    int j;
    w_win_rr = '0;
    for (int k = N; k >= 1; k--) begin
      j = int'(last_q) - k;
      if (j < 0) j = j + N;
      if (w_cand[j[W-1:0]]) w_win_rr = W'(j);
    end
  end

  assign w_win = rr_en ? w_win_rr : w_win_fix;

  // Next-state for the output register, capture register and grant pointer.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    last_d    = last_q;
    if (w_load) begin
      if (w_cand != '0) begin
        state_d   = S_HOLD;
        idx_d     = w_win;
        last_d    = w_win;
        pending_d = w_cand & ~({{(N-1){1'b0}}, 1'b1} << w_win);
      end else begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    end else begin
      // Output is stalled: keep merging new requests into the pending set.
      pending_d = w_cand;
    end
  end

  // Popcount of the pending set that will be registered this edge.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d = cnt_d + {{W{1'b0}}, pending_d[i[W-1:0]]};
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign idx       = idx_q;
  assign pend_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_enc_rr
//  Description : Directed self-checking bench for prio_enc_rr (N=8 and N=5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prio_enc_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] req8;
  logic       rr8;
  logic       rdy8;
  logic       val8;
  logic [2:0] idx8;
  logic [3:0] cnt8;
  logic [4:0] req5;
  logic       rr5;
  logic       rdy5;
  logic       val5;
  logic [2:0] idx5;
  logic [3:0] cnt5;

  int n_vec = 0;
  int n_bad = 0;

  prio_enc_rr #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .rr_en(rr8), .out_ready(rdy8),
    .out_valid(val8), .idx(idx8), .pend_cnt(cnt8)
  );

  prio_enc_rr #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .rr_en(rr5), .out_ready(rdy5),
    .out_valid(val5), .idx(idx5), .pend_cnt(cnt5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic v, input logic [2:0] i, input logic [3:0] c);
    chk({tag, ".valid"}, {31'd0, val8}, {31'd0, v});
    chk({tag, ".idx"},   {29'd0, idx8}, {29'd0, i});
    chk({tag, ".cnt"},   {28'd0, cnt8}, {28'd0, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] rr_seq [9];
    rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

    rst_n = 1'b0;
    req8 = '0; rr8 = 1'b0; rdy8 = 1'b1;
    req5 = '0; rr5 = 1'b0; rdy5 = 1'b1;
    #12;
    chk8("rst", 1'b0, 3'd0, 4'd0);
    chk("rst5.valid", {31'd0, val5}, 32'd0);
    chk("rst5.cnt", {28'd0, cnt5}, 32'd0);
    rst_n = 1'b1;

    // Fixed order, single-cycle pulse of three requests drains 5, 2, 1.
    req8 = 8'b0010_0110;
    tick(); req8 = '0;
    chk8("fix0", 1'b1, 3'd5, 4'd2);
    tick(); chk8("fix1", 1'b1, 3'd2, 4'd1);
    tick(); chk8("fix2", 1'b1, 3'd1, 4'd0);
    tick(); chk8("fixidle", 1'b0, 3'd1, 4'd0);

    // Backpressure: idx 5 held while a req[7] pulse is captured.
    rdy8 = 1'b0; req8 = 8'h20;
    tick(); req8 = '0;
    chk8("bp0", 1'b1, 3'd5, 4'd0);
    tick(); req8 = 8'h80;
    tick(); req8 = '0;
    chk8("bp1", 1'b1, 3'd5, 4'd1);
    tick(); tick();
    chk8("bp2", 1'b1, 3'd5, 4'd1);
    rdy8 = 1'b1; #1;
    chk8("bp3", 1'b1, 3'd5, 4'd1);
    tick(); chk8("bp4", 1'b1, 3'd7, 4'd0);
    tick(); chk8("bp5", 1'b0, 3'd7, 4'd0);

    // Round-robin fairness with all requests held, then fixed starvation.
    do_reset();
    rr8 = 1'b1; req8 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk8($sformatf("rr%0d", k), 1'b1, rr_seq[k], 4'd7);
    end
    rr8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk8($sformatf("fx%0d", k), 1'b1, 3'd7, 4'd7);
    end
    req8 = '0;

    // Small N: two held requests alternate under round-robin.
    do_reset();
    rr5 = 1'b1; req5 = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("n5idx%0d", k), {29'd0, idx5}, (k % 2 == 0) ? 32'd4 : 32'd0);
      chk($sformatf("n5cnt%0d", k), {28'd0, cnt5}, 32'd1);
      chk($sformatf("n5cap%0d", k), {31'd0, (cnt5 <= 4'd2)}, 32'd1);
    end
    req5 = '0; rr5 = 1'b0;

    // Mode switch keeps the last-granted pointer.
    do_reset();
    rr8 = 1'b1; req8 = 8'b0000_1110;
    tick(); chk8("ms0", 1'b1, 3'd3, 4'd2);
    rr8 = 1'b0;
    tick(); chk8("ms1", 1'b1, 3'd3, 4'd2);
    rr8 = 1'b1;
    tick(); chk8("ms2", 1'b1, 3'd2, 4'd2);
    tick(); chk8("ms3", 1'b1, 3'd1, 4'd2);
    tick(); chk8("ms4", 1'b1, 3'd3, 4'd2);
    req8 = '0;

    // Asynchronous reset in the middle of a HOLD, then fresh arbitration.
    do_reset();
    rr8 = 1'b0; rdy8 = 1'b0; req8 = 8'h24;
    tick(); req8 = '0;
    chk8("ar0", 1'b1, 3'd5, 4'd1);
    tick();
    chk8("ar1", 1'b1, 3'd5, 4'd1);
    #3 rst_n = 1'b0;
    #1 chk8("ar2", 1'b0, 3'd0, 4'd0);
    #1 rst_n = 1'b1;
    rdy8 = 1'b1; rr8 = 1'b1; req8 = 8'h41;
    tick(); req8 = '0;
    chk8("ar3", 1'b1, 3'd6, 4'd1);
    tick(); chk8("ar4", 1'b1, 3'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
